// File: rtl/sha256_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : sha256_pkg                                            |
// | Purpose  : Shared SHA-256 constants and the padder state type.   |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package sha256_pkg;

  localparam int SHA256_BLOCK_W     = 512;
  localparam int SHA256_LEN_FIELD_W = 64;
  localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;

  // Initial hash value, H0[0] first.
  localparam logic [31:0] SHA256_H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Round constants, K[0] first.
  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Padder FSM: collect bytes, then emit one to three blocks.
  typedef enum logic [1:0] {
    FILL      = 2'd0,
    EMIT_DATA = 2'd1,
    EMIT_PAD  = 2'd2,
    EMIT_LEN  = 2'd3
  } pad_state_t;

endpackage : sha256_pkg
`default_nettype wire

// File: rtl/sha256_byte_insert.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : sha256_byte_insert                                    |
// | Purpose  : Writes up to BEAT_BYTES left-justified bytes, and     |
// |            optionally the 0x80 pad byte after them, into a       |
// |            512-bit block at a byte offset (byte 0 = bits 511:504)|
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module sha256_byte_insert
  import sha256_pkg::*;
#(
  parameter int BEAT_BYTES = 1
) (
  input  logic [SHA256_BLOCK_W-1:0]   buf_in,
  input  logic [6:0]                  offset,
  input  logic [8*BEAT_BYTES-1:0]     data,
  input  logic [$clog2(BEAT_BYTES):0] nbytes,
  input  logic                        insert_pad,
  output logic [SHA256_BLOCK_W-1:0]   buf_out
);

  // Overlay message bytes and the pad marker; writes past byte 63 are dropped.
  always_comb begin
    int off;
    int nb;
    off     = int'(offset);
    nb      = int'(nbytes);
    buf_out = buf_in;
    for (int j = 0; j < BEAT_BYTES; j++) begin
      if ((j < nb) && ((off + j) < 64)) begin
        buf_out[511 - 8*(off + j) -: 8] = data[8*BEAT_BYTES - 1 - 8*j -: 8];
      end
    end
    if (insert_pad && ((off + nb) < 64)) begin
      buf_out[511 - 8*(off + nb) -: 8] = SHA256_PAD_BYTE;
    end
  end

endmodule : sha256_byte_insert
`default_nettype wire

// File: rtl/sha256_stream_padder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : sha256_stream_padder                                  |
// | Purpose  : Packs a byte stream into 512-bit SHA-256 blocks and   |
// |            appends the 0x80 marker, zero fill and 64-bit length. |
// | Options  : SHA256_PAD_LEN_CHECK_EN adds the sticky len_err flag  |
// |            for byte-counter overflow.                            |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module sha256_stream_padder
  import sha256_pkg::*;
#(
  parameter int BEAT_BYTES = 1,
  parameter int MSG_LEN_W  = 61
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [8*BEAT_BYTES-1:0]     in_data,
  input  logic [$clog2(BEAT_BYTES):0] in_nbytes,
  input  logic                        in_last,
  output logic                        blk_valid,
  input  logic                        blk_ready,
  output logic [SHA256_BLOCK_W-1:0]   blk_data,
  output logic                        blk_first,
  output logic                        blk_last
`ifdef SHA256_PAD_LEN_CHECK_EN
  ,
  output logic                        len_err
`endif
);

  pad_state_t                  r_state, w_state_n;
  logic [6:0]                  r_ptr, w_ptr_n;
  logic [MSG_LEN_W-1:0]        r_count, w_count_n;
  logic [SHA256_BLOCK_W-1:0]   r_buf, w_buf_n;
  logic                        r_first, w_first_n;
  logic                        r_pend, w_pend_n;

  logic                        w_accept;
  logic                        w_blk_hs;
  logic [6:0]                  w_ptr_sum;
  logic [MSG_LEN_W-1:0]        w_count_sum;
  logic [SHA256_LEN_FIELD_W-1:0] w_len_next;
  logic [SHA256_LEN_FIELD_W-1:0] w_len_cur;
  logic [SHA256_BLOCK_W-1:0]   w_ins_buf;

  assign in_ready  = (r_state == FILL);
  assign blk_valid = (r_state != FILL);
  assign blk_data  = r_buf;
  assign blk_first = blk_valid & r_first;
  assign blk_last  = (r_state == EMIT_LEN);

  assign w_accept    = in_valid & in_ready;
  assign w_blk_hs    = blk_valid & blk_ready;
  assign w_ptr_sum   = r_ptr + 7'(in_nbytes);
  assign w_count_sum = r_count + MSG_LEN_W'(in_nbytes);
  // Bit length = bytes * 8; the counter is at most 61 bits so this fits 64.
  assign w_len_next  = SHA256_LEN_FIELD_W'({w_count_sum, 3'b000});
  assign w_len_cur   = SHA256_LEN_FIELD_W'({r_count, 3'b000});

  sha256_byte_insert #(
    .BEAT_BYTES (BEAT_BYTES)
  ) u_insert (
    .buf_in     (r_buf),
    .offset     (r_ptr),
    .data       (in_data),
    .nbytes     (in_nbytes),
    .insert_pad (in_last),
    .buf_out    (w_ins_buf)
  );

  // State and datapath registers; reset discards any partial message.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FILL;
      r_ptr   <= '0;
      r_count <= '0;
      r_buf   <= '0;
      r_first <= 1'b1;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      r_count <= w_count_n;
      r_buf   <= w_buf_n;
      r_first <= w_first_n;
      r_pend  <= w_pend_n;
    end
  end

  // Next-state and buffer update: fill, then emit data/pad/length blocks.
  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_count_n = r_count;
    w_buf_n   = r_buf;
    w_first_n = r_first;
    w_pend_n  = r_pend;
    case (r_state)
      FILL: begin
        if (w_accept) begin
          w_buf_n   = w_ins_buf;
          w_ptr_n   = w_ptr_sum;
          w_count_n = w_count_sum;
          if (in_last) begin
            if (w_ptr_sum <= 7'd55) begin
              // Marker and length both fit in this block.
              w_buf_n   = {w_ins_buf[SHA256_BLOCK_W-1:SHA256_LEN_FIELD_W], w_len_next};
              w_state_n = EMIT_LEN;
            end else if (w_ptr_sum < 7'd64) begin
              w_state_n = EMIT_PAD;
            end else begin
              // Block is full of data; marker goes into the next block.
              w_pend_n  = 1'b1;
              w_state_n = EMIT_DATA;
            end
          end else if (w_ptr_sum == 7'd64) begin
            w_state_n = EMIT_DATA;
          end
        end
      end
      EMIT_DATA: begin
        if (w_blk_hs) begin
          w_first_n = 1'b0;
          w_ptr_n   = '0;
          if (r_pend) begin
            w_buf_n   = {SHA256_PAD_BYTE, 440'd0, w_len_cur};
            w_pend_n  = 1'b0;
            w_state_n = EMIT_LEN;
          end else begin
            w_buf_n   = '0;
            w_state_n = FILL;
          end
        end
      end
      EMIT_PAD: begin
        if (w_blk_hs) begin
          w_first_n = 1'b0;
          w_buf_n   = {448'd0, w_len_cur};
          w_state_n = EMIT_LEN;
        end
      end
      EMIT_LEN: begin
        if (w_blk_hs) begin
          w_first_n = 1'b1;
          w_buf_n   = '0;
          w_ptr_n   = '0;
          w_count_n = '0;
          w_state_n = FILL;
        end
      end
      default: w_state_n = FILL;
    endcase
  end

`ifdef SHA256_PAD_LEN_CHECK_EN
  logic r_len_err;
  logic r_in_msg;
  logic w_wrap;

  // With nbytes < 2^MSG_LEN_W a wrap shows up as the sum dropping below the old count.
  assign w_wrap  = (w_count_sum < r_count);
  assign len_err = r_len_err;

  // Sticky overflow flag, cleared by the first beat of the following message.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_len_err <= 1'b0;
      r_in_msg  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_in_msg  <= 1'b1;
        r_len_err <= (r_in_msg ? r_len_err : 1'b0) | w_wrap;
      end else if ((r_state == EMIT_LEN) && w_blk_hs) begin
        r_in_msg  <= 1'b0;
      end
    end
  end
`endif

endmodule : sha256_stream_padder
`default_nettype wire
